// File: rtl/mod_nibble_core.sv
// mod_nibble_core: fetch/execute sequencer for a nibble-wide ISA that runs
// out of a 32x4 memory with registered read data.
//
// Ports:
//   i_clk, i_rst         clock (posedge) and async active-high reset
//   i_en                 step enable; every state element holds when low
//   o_mem_sel/rw/addr    memory request, combinational from state, gated by i_en
//   o_mem_wData          write data (accumulator)
//   i_mem_rData          read data, valid in the CAP cycle after a REQ
//   o_pc, o_acc, o_carry architectural state for display
//   o_out, o_out_valid   output register and its update pulse
//   o_halted             high once HLT has executed
//
// state  | meaning
// F_REQ  | request opcode at pc
// F_CAP  | decode opcode, pc+1, execute NOP/OUT
// O1_REQ | request first operand at pc
// O1_CAP | immediate execute (LDI/ADDI) or latch addr[4], pc+1
// O2_REQ | request second operand at pc
// O2_CAP | latch addr[3:0], pc+1, resolve jumps
// D_REQ  | read data nibble at latched address
// D_CAP  | execute LD/ADD
// W      | write acc to latched address
// HALT   | stopped until reset

module mod_nibble_core #(
  parameter logic [4:0] RESET_PC = 5'd0
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_en,
  output logic       o_mem_sel,
  output logic       o_mem_rw,
  output logic [4:0] o_mem_addr,
  output logic [3:0] o_mem_wData,
  input  logic [3:0] i_mem_rData,
  output logic [4:0] o_pc,
  output logic [3:0] o_acc,
  output logic       o_carry,
  output logic [3:0] o_out,
  output logic       o_out_valid,
  output logic       o_halted
);

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LDI  = 4'h1;
  localparam logic [3:0] OP_LD   = 4'h2;
  localparam logic [3:0] OP_ST   = 4'h3;
  localparam logic [3:0] OP_ADD  = 4'h4;
  localparam logic [3:0] OP_ADDI = 4'h5;
  localparam logic [3:0] OP_JMP  = 4'h6;
  localparam logic [3:0] OP_JC   = 4'h7;
  localparam logic [3:0] OP_JZ   = 4'h8;
  localparam logic [3:0] OP_OUT  = 4'h9;
  localparam logic [3:0] OP_HLT  = 4'hF;

  typedef enum logic [3:0] {
    F_REQ, F_CAP, O1_REQ, O1_CAP, O2_REQ, O2_CAP, D_REQ, D_CAP, W, HALT
  } state_t;

  state_t     state_q, state_d;
  logic [4:0] pc_q, pc_d;
  logic [3:0] acc_q, acc_d;
  logic       carry_q, carry_d;
  logic [3:0] out_q, out_d;
  logic [3:0] opc_q, opc_d;
  logic [4:0] addr_q, addr_d;
  logic       out_valid;
  logic [4:0] sum;
  logic [4:0] target;
  logic       z;
  logic       sel;

  assign sum    = {1'b0, acc_q} + {1'b0, i_mem_rData};
  assign target = {addr_q[4], i_mem_rData};
  assign z      = (acc_q == 4'd0);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= F_REQ;
      pc_q    <= RESET_PC;
      acc_q   <= 4'd0;
      carry_q <= 1'b0;
      out_q   <= 4'd0;
      opc_q   <= OP_NOP;
      addr_q  <= 5'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      out_q   <= out_d;
      opc_q   <= opc_d;
      addr_q  <= addr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    acc_d     = acc_q;
    carry_d   = carry_q;
    out_d     = out_q;
    opc_d     = opc_q;
    addr_d    = addr_q;
    out_valid = 1'b0;
    if (i_en) begin
      case (state_q)
        F_REQ:  state_d = F_CAP;
        F_CAP: begin
          opc_d = i_mem_rData;
          pc_d  = pc_q + 5'd1;
          if (i_mem_rData == OP_HLT) begin
            state_d = HALT;
          end else if (i_mem_rData >= OP_LDI && i_mem_rData <= OP_JZ) begin
            state_d = O1_REQ;
          end else begin
            state_d = F_REQ;
          end
          if (i_mem_rData == OP_OUT) begin
            out_d     = acc_q;
            out_valid = 1'b1;
          end
        end
        O1_REQ: state_d = O1_CAP;
        O1_CAP: begin
          pc_d = pc_q + 5'd1;
          if (opc_q == OP_LDI) begin
            acc_d   = i_mem_rData;
            state_d = F_REQ;
          end else if (opc_q == OP_ADDI) begin
            {carry_d, acc_d} = sum;
            state_d = F_REQ;
          end else begin
            // only bit 0 of the high operand nibble is an address bit
            addr_d  = {i_mem_rData[0], 4'd0};
            state_d = O2_REQ;
          end
        end
        O2_REQ: state_d = O2_CAP;
        O2_CAP: begin
          pc_d   = pc_q + 5'd1;
          addr_d = target;
          case (opc_q)
            OP_JMP:  begin pc_d = target;                state_d = F_REQ; end
            OP_JC:   begin if (carry_q) pc_d = target;   state_d = F_REQ; end
            OP_JZ:   begin if (z) pc_d = target;         state_d = F_REQ; end
            OP_ST:   state_d = W;
            default: state_d = D_REQ;
          endcase
        end
        D_REQ:  state_d = D_CAP;
        D_CAP: begin
          if (opc_q == OP_ADD) begin
            {carry_d, acc_d} = sum;
          end else begin
            acc_d = i_mem_rData;
          end
          state_d = F_REQ;
        end
        W:       state_d = F_REQ;
        HALT:    state_d = HALT;
        default: state_d = F_REQ;
      endcase
    end
  end

  assign sel = i_en & (state_q == F_REQ || state_q == O1_REQ || state_q == O2_REQ ||
                       state_q == D_REQ || state_q == W);

  assign o_mem_sel   = sel;
  assign o_mem_rw    = sel & (state_q == W);
  assign o_mem_addr  = !sel ? 5'd0 :
                       (state_q == D_REQ || state_q == W) ? addr_q : pc_q;
  assign o_mem_wData = acc_q;

  assign o_pc        = pc_q;
  assign o_acc       = acc_q;
  assign o_carry     = carry_q;
  assign o_out       = out_q;
  assign o_out_valid = out_valid;
  assign o_halted    = (state_q == HALT);

endmodule
